univ_shift_reg: RTL

Parametrised universal shift register with multi-cycle shift commands. Generalises the single-bit D flip-flop to a WIDTH-bit register with parallel load, clear, logical/arithmetic shift and rotate in both directions. A command shifts by a programmable number of positions, one position per clock, and reports `busy` and a `done` pulse. Used as the serialiser/deserialiser and bit-manipulation register in the lab datapath.

---
 rtl/univ_shift_pkg.sv | 30 +++
 rtl/univ_shift_dp.sv | 74 +++++++
 rtl/univ_shift_reg.sv | 128 ++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
// Shared types for the universal shift register: command codes and FSM states.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'd0,
    MODE_LOAD  = 3'd1,
    MODE_SHL   = 3'd2,
    MODE_SHR   = 3'd3,
    MODE_ROL   = 3'd4,
    MODE_ROR   = 3'd5,
    MODE_ASR   = 3'd6,
    MODE_CLEAR = 3'd7
  } mode_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // True for the codes that move bits (and therefore run for `amount` edges).
  function automatic logic is_shift_mode(input mode_e m);
    logic r;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/univ_shift_dp.sv
// Datapath of the universal shift register: q register, shifted-out bit
// register and the next-value mux selected by the effective operation.
module univ_shift_dp
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  mode_e            op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             sout_r;
  logic             sout_nxt_s;

  // Next-value mux; sout only moves when a bit actually leaves the register.
  always_comb begin
    q_nxt_s    = q_r;
    sout_nxt_s = sout_r;
    if (en) begin
      case (op)
        MODE_HOLD:  q_nxt_s = q_r;
        MODE_LOAD:  q_nxt_s = d;
        MODE_SHL: begin
          q_nxt_s    = {q_r[WIDTH-2:0], sin};
          sout_nxt_s = q_r[WIDTH-1];
        end
        MODE_SHR: begin
          q_nxt_s    = {sin, q_r[WIDTH-1:1]};
          sout_nxt_s = q_r[0];
        end
        MODE_ROL: begin
          q_nxt_s    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          sout_nxt_s = q_r[WIDTH-1];
        end
        MODE_ROR: begin
          q_nxt_s    = {q_r[0], q_r[WIDTH-1:1]};
          sout_nxt_s = q_r[0];
        end
        MODE_ASR: begin
          q_nxt_s    = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
          sout_nxt_s = q_r[0];
        end
        MODE_CLEAR: q_nxt_s = '0;
        default:    q_nxt_s = q_r;
      endcase
    end else begin
      q_nxt_s    = q_r;
      sout_nxt_s = sout_r;
    end
  end

  // Data and shifted-out bit registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_r    <= '0;
      sout_r <= 1'b0;
    end else begin
      q_r    <= q_nxt_s;
      sout_r <= sout_nxt_s;
    end
  end

  assign q    = q_r;
  assign sout = sout_r;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: accepts a command, runs multi-position shifts one
// position per clock, reports busy while shifting and pulses done at the end.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  mode_e            mode_r;
  mode_e            mode_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  mode_e            mode_in_s;
  logic [CNT_W-1:0] n_s;
  logic             dp_en_s;
  mode_e            dp_mode_s;

  assign mode_in_s = mode_e'(mode);
  // Oversized requests collapse to a full-width shift.
  assign n_s = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;

  // Next-state, counter, mode latch and datapath control.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mode_nxt_s  = mode_r;
    busy_nxt_s  = 1'b0;
    done_nxt_s  = 1'b0;
    dp_en_s     = 1'b0;
    dp_mode_s   = MODE_HOLD;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          done_nxt_s = 1'b1;
          if (is_shift_mode(mode_in_s)) begin
            if (n_s == CNT_W'(0)) begin
              dp_en_s = 1'b0;
            end else if (n_s == CNT_W'(1)) begin
              dp_en_s   = 1'b1;
              dp_mode_s = mode_in_s;
            end else begin
              // First shift happens now; the rest run from the latched mode.
              dp_en_s     = 1'b1;
              dp_mode_s   = mode_in_s;
              done_nxt_s  = 1'b0;
              busy_nxt_s  = 1'b1;
              state_nxt_s = ST_SHIFT;
              cnt_nxt_s   = n_s - CNT_W'(1);
              mode_nxt_s  = mode_in_s;
            end
          end else begin
            dp_en_s   = 1'b1;
            dp_mode_s = mode_in_s;
          end
        end else begin
          dp_en_s = 1'b0;
        end
      end
      ST_SHIFT: begin
        dp_en_s   = 1'b1;
        dp_mode_s = mode_r;
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = '0;
          done_nxt_s  = 1'b1;
        end else begin
          cnt_nxt_s  = cnt_r - CNT_W'(1);
          busy_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Control state registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      mode_r  <= MODE_HOLD;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mode_r  <= mode_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  univ_shift_dp #(.WIDTH(WIDTH)) u_dp (
    .clk  (clk),
    .rstn (rstn),
    .en   (dp_en_s),
    .op   (dp_mode_s),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .sout (sout)
  );

  assign busy = busy_r;
  assign done = done_r;

endmodule
